dds_serial_receiver: RTL
========================

# dds_serial_receiver

Synthesizable model of the DDS serial port: receives the `sclk`/`csb`/`sdio`/`io_update`/`reset` stream produced by `dds_controller` and decodes it back into frequency, phase and amplitude words. It sits on the DDS side of the link. It is used for closed-loop checking of `dds_controller` in simulation and on hardware loopback, and as a stand-in when no DDS is fitted.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on every serial input; legal values ≥2.
- `FREQ_ADDR`, default 13'h01AB: start address of the 6-byte frequency tuning word.
- `PHASE_ADDR`, default 13'h01AD: start address of the 2-byte phase word.
- `AMP_ADDR`, default 13'h040C: start address of the 2-byte amplitude word.

Ports:
- `clk_in` in 1: system clock. One clock only.
- `reset_in` in 1: reset; synchronous, active-high.
- `sclk_in` in 1: serial clock, asynchronous to `clk_in`.
- `csb_in` in 1: chip select, active-low.
- `sdio_in` in 1: serial data.
- `io_update_in` in 1: commit strobe.
- `dds_reset_in` in 1: DDS reset line, active-high.
- `freq_out` out 48: committed frequency word.
- `phase_out` out 14: committed phase word.
- `amp_out` out 10: committed amplitude word.
- `freq_dv_out`, `phase_dv_out`, `amp_dv_out` out 1 each: one-cycle commit pulses.
- `frame_err_out` out 1: one-cycle pulse when a malformed frame is detected.

## Operation
- Input sampling: all five serial inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronized copies.
- Data capture: `sdio` is sampled on each synchronized `sclk` rising edge while `csb` is low. Bits are MSB first and shift into a 64-bit register. A 7-bit bit counter saturates at 127.
- Frame layout:
  - 16-bit instruction: bit15 = R/W (0 = write), bits14:13 = length code, bits12:0 = address.
  - The instruction is followed by the data bytes.
- FSM states:
  - IDLE → INSTR on falling edge of `csb`.
  - INSTR → DATA after 16 bits.
  - DATA → CHECK on rising edge of `csb`.
  - INSTR → CHECK on rising edge of `csb`.
  - CHECK → IDLE after one cycle.
- CHECK is a valid write when R/W = 0 and one of these holds:
  - address = `FREQ_ADDR` and exactly 64 bits received;
  - address = `PHASE_ADDR` or `AMP_ADDR` and exactly 32 bits received.
- On a valid write: load the matching shadow register. Phase takes data[13:0]; amplitude takes data[9:0]. Set that register's pending bit.
- Frames rejected with a `frame_err_out` pulse (shadow unchanged):
  - R/W = 1;
  - bit count differs from the count required for a known address;
  - bit count below 16.
- Unknown address with R/W = 0: discarded with no error.
- Commit: on a synchronized rising edge of `io_update`, copy each pending shadow to its output, pulse that output's dv, and clear all pending bits. With no bits pending, an `io_update` does nothing.
- `io_update` arriving while `csb` is low commits only frames already completed; the frame in flight continues unaffected.
- `dds_reset_in` high:
  - shadows, outputs and pending bits cleared to 0;
  - FSM forced to IDLE and any frame in flight aborted;
  - no dv pulses and no error pulse.
- `reset_in`: same effect as `dds_reset_in`, and it also clears the synchronizers.

## Timing
- Reset value of every output is 0.
- `sclk` high time and low time must each be ≥ `SYNC_STAGES`+1 `clk_in` cycles. The gap from the last `sclk` rising edge to `csb` rising must be ≥ 2 cycles.
- The shadow register is loaded exactly `SYNC_STAGES`+2 cycles after `csb_in` rises.
- dv pulses are asserted exactly `SYNC_STAGES`+2 cycles after `io_update_in` rises, and `freq_out`/`phase_out`/`amp_out` take their new values in that same cycle. Each dv pulse lasts exactly one cycle.
- `csb` rising and `io_update` rising in the same synchronized cycle: CHECK runs first, and the commit is taken one cycle later, so it includes that frame.
- `frame_err_out` is asserted in the CHECK cycle.

## Configuration
- `DDS_RX_ERR_CNT_EN` defined: adds output `err_cnt_out` (8 bits). It increments on every `frame_err_out` pulse, saturates at 255, and is cleared by `reset_in` only.
- Without `DDS_RX_ERR_CNT_EN`: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package `dds_pkg` holds:
  - the FSM state enum;
  - the default addresses;
  - the length constants (instruction 16, frequency 48, phase 14, amplitude 10);
  - the frame bit counts (64 and 32).
  `dds_controller` uses the same package.
- One sub-module: `dds_rx_sync`, a parameterized N-stage synchronizer with rising/falling edge outputs, instantiated once per serial input.

## Test plan
- Frequency write, loopback from `dds_controller` with `freq_in`=48'h123456789ABC → `freq_out`=48'h123456789ABC, a single `freq_dv_out` pulse, no other dv pulses.
- Phase write then amplitude write, one shared `io_update`, with 14'h2A5A and 10'h3C3 → both outputs update and both dv pulses arrive in the same cycle.
- Phase frame cut after 24 bits → `frame_err_out` pulse, `phase_out` holds its previous value, and no dv pulse on the next `io_update`.
- Frame with R/W = 1 to `FREQ_ADDR`, and a write to address 13'h0000 → an error pulse for the first frame only, and no output change for either.
- `dds_reset_in` pulsed mid-frame after 40 bits of a frequency frame → all outputs 0, IDLE, and the next full frame decodes correctly.
- 100 random frequency/phase/amplitude mixes from `dds_controller` → every output matches the driven value. With `DDS_RX_ERR_CNT_EN` defined, `err_cnt_out` stays 0.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS serial-link definitions: FSM states, default register
// addresses, field widths and frame bit counts.
// Used by both dds_controller and dds_serial_receiver.
package dds_pkg;

    localparam int unsigned ADDR_W           = 13;
    localparam int unsigned INSTR_LEN        = 16;
    localparam int unsigned FREQ_W           = 48;
    localparam int unsigned PHASE_W          = 14;
    localparam int unsigned AMP_W            = 10;
    localparam int unsigned FREQ_FRAME_BITS  = 64;
    localparam int unsigned SHORT_FRAME_BITS = 32;
    localparam int unsigned SHIFT_W          = 64;
    localparam int unsigned BIT_CNT_W        = 7;
    localparam int unsigned ERR_CNT_W        = 8;

    localparam logic [ADDR_W-1:0] DDS_FREQ_ADDR  = 13'h01AB;
    localparam logic [ADDR_W-1:0] DDS_PHASE_ADDR = 13'h01AD;
    localparam logic [ADDR_W-1:0] DDS_AMP_ADDR   = 13'h040C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSTR,
        ST_DATA,
        ST_CHECK
    } dds_state_t;

    // 16-bit instruction word as it appears on the wire (MSB first).
    typedef struct packed {
        logic              rw;
        logic [1:0]        len;
        logic [ADDR_W-1:0] addr;
    } dds_instr_t;

endpackage

// File: rtl/dds_rx_sync.sv
// N-stage synchronizer for one asynchronous input, with single-cycle
// rising/falling edge indications derived from the synchronized copy.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears the chain)
//   d          - asynchronous input
//   q          - synchronized level
//   rise_c     - high for one cycle after q goes 0->1
//   fall_c     - high for one cycle after q goes 1->0
module dds_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              q_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= '0;
            q_prev <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], d};
            q_prev <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~q_prev;
    assign fall_c = ~chain[STAGES-1] & q_prev;

endmodule

// File: rtl/dds_serial_receiver.sv
// DDS-side model of the serial port driven by dds_controller. Decodes
// write frames into shadow registers and commits them to the outputs on
// io_update.
// Ports:
//   clk_in, reset_in          - clock, synchronous active-high reset
//   sclk_in, csb_in, sdio_in  - asynchronous serial clock/select/data
//   io_update_in              - commit strobe
//   dds_reset_in              - DDS reset line (clears decoded state)
//   freq_out/phase_out/amp_out            - committed words
//   freq_dv_out/phase_dv_out/amp_dv_out   - one-cycle commit pulses
//   frame_err_out             - one-cycle pulse on a malformed frame
//   err_cnt_out               - saturating error count, only when
//                               DDS_RX_ERR_CNT_EN is defined
module dds_serial_receiver
    import dds_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] FREQ_ADDR   = DDS_FREQ_ADDR,
    parameter logic [ADDR_W-1:0] PHASE_ADDR  = DDS_PHASE_ADDR,
    parameter logic [ADDR_W-1:0] AMP_ADDR    = DDS_AMP_ADDR
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               sclk_in,
    input  logic               csb_in,
    input  logic               sdio_in,
    input  logic               io_update_in,
    input  logic               dds_reset_in,
    output logic [FREQ_W-1:0]  freq_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic [AMP_W-1:0]   amp_out,
    output logic               freq_dv_out,
    output logic               phase_dv_out,
    output logic               amp_dv_out,
    output logic               frame_err_out
`ifdef DDS_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_out
`endif
);

    // Synchronized inputs and edges.
    logic sclk_q_unused, sclk_rise, sclk_fall_unused;
    logic csb_q, csb_rise, csb_fall;
    logic sdio_q, sdio_rise_unused, sdio_fall_unused;
    logic io_q_unused, io_rise, io_fall_unused;
    logic dds_rst, dds_rst_rise_unused, dds_rst_fall_unused;

    dds_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk_in), .rst(reset_in), .d(sclk_in),
        .q(sclk_q_unused), .rise_c(sclk_rise), .fall_c(sclk_fall_unused));
    dds_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (
        .clk(clk_in), .rst(reset_in), .d(csb_in),
        .q(csb_q), .rise_c(csb_rise), .fall_c(csb_fall));
    dds_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sdio (
        .clk(clk_in), .rst(reset_in), .d(sdio_in),
        .q(sdio_q), .rise_c(sdio_rise_unused), .fall_c(sdio_fall_unused));
    dds_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_io (
        .clk(clk_in), .rst(reset_in), .d(io_update_in),
        .q(io_q_unused), .rise_c(io_rise), .fall_c(io_fall_unused));
    dds_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(clk_in), .rst(reset_in), .d(dds_reset_in),
        .q(dds_rst), .rise_c(dds_rst_rise_unused), .fall_c(dds_rst_fall_unused));

    dds_state_t           state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    dds_instr_t           instr_q;

    logic capture_c, check_c, enter_check_c;
    logic is_freq, is_phase, is_amp, cnt_long, cnt_short, len_ok, bad_frame;
    logic load_freq, load_phase, load_amp;

    logic [FREQ_W-1:0]  freq_sh;
    logic [PHASE_W-1:0] phase_sh;
    logic [AMP_W-1:0]   amp_sh;
    logic               pend_freq, pend_phase, pend_amp;
    logic               commit_req_q, commit_c;

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state controls; dds_reset overrides everything.
    always_comb begin
        state_d       = state_q;
        capture_c     = 1'b0;
        check_c       = 1'b0;
        enter_check_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csb_fall) state_d = ST_INSTR;
            end
            ST_INSTR: begin
                capture_c = sclk_rise & ~csb_q;
                if (csb_rise) begin
                    state_d = ST_CHECK;
                end else if (bit_cnt_q == BIT_CNT_W'(INSTR_LEN)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                capture_c = sclk_rise & ~csb_q;
                if (csb_rise) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                check_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (dds_rst) begin
            state_d   = ST_IDLE;
            capture_c = 1'b0;
            check_c   = 1'b0;
        end
        enter_check_c = (state_d == ST_CHECK) && (state_q != ST_CHECK);
    end

    // Shift register, saturating bit counter and instruction latch.
    always_ff @(posedge clk_in) begin
        if (reset_in || dds_rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            instr_q   <= '0;
        end else if (state_q == ST_IDLE && csb_fall) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (capture_c) begin
            shift_q <= {shift_q[SHIFT_W-2:0], sdio_q};
            if (bit_cnt_q != {BIT_CNT_W{1'b1}}) begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
            if (bit_cnt_q == BIT_CNT_W'(INSTR_LEN - 1)) begin
                instr_q <= dds_instr_t'({shift_q[INSTR_LEN-2:0], sdio_q});
            end
        end
    end

    // Frame classification; stable from the csb rise through CHECK.
    assign is_freq   = (instr_q.addr == FREQ_ADDR);
    assign is_phase  = (instr_q.addr == PHASE_ADDR);
    assign is_amp    = (instr_q.addr == AMP_ADDR);
    assign cnt_long  = (bit_cnt_q == BIT_CNT_W'(FREQ_FRAME_BITS));
    assign cnt_short = (bit_cnt_q == BIT_CNT_W'(SHORT_FRAME_BITS));
    assign len_ok    = (is_freq & cnt_long) | ((is_phase | is_amp) & cnt_short);
    assign bad_frame = (bit_cnt_q < BIT_CNT_W'(INSTR_LEN)) | instr_q.rw
                     | ((is_freq | is_phase | is_amp) & ~len_ok);

    assign load_freq  = check_c & ~bad_frame & is_freq & cnt_long;
    assign load_phase = check_c & ~bad_frame & is_phase & cnt_short;
    assign load_amp   = check_c & ~bad_frame & is_amp & cnt_short;

    // A commit requested while CHECK runs waits one cycle so it includes
    // the frame just checked.
    assign commit_c = commit_req_q & (state_q != ST_CHECK);

    always_ff @(posedge clk_in) begin
        if (reset_in || dds_rst) begin
            commit_req_q <= 1'b0;
        end else begin
            commit_req_q <= io_rise | (commit_req_q & ~commit_c);
        end
    end

    // Shadows, pending bits, committed outputs and pulses.
    always_ff @(posedge clk_in) begin
        if (reset_in || dds_rst) begin
            freq_sh       <= '0;
            phase_sh      <= '0;
            amp_sh        <= '0;
            pend_freq     <= 1'b0;
            pend_phase    <= 1'b0;
            pend_amp      <= 1'b0;
            freq_out      <= '0;
            phase_out     <= '0;
            amp_out       <= '0;
            freq_dv_out   <= 1'b0;
            phase_dv_out  <= 1'b0;
            amp_dv_out    <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            freq_dv_out   <= 1'b0;
            phase_dv_out  <= 1'b0;
            amp_dv_out    <= 1'b0;
            frame_err_out <= enter_check_c & bad_frame;
            if (commit_c) begin
                if (pend_freq) begin
                    freq_out    <= freq_sh;
                    freq_dv_out <= 1'b1;
                end
                if (pend_phase) begin
                    phase_out    <= phase_sh;
                    phase_dv_out <= 1'b1;
                end
                if (pend_amp) begin
                    amp_out    <= amp_sh;
                    amp_dv_out <= 1'b1;
                end
                pend_freq  <= 1'b0;
                pend_phase <= 1'b0;
                pend_amp   <= 1'b0;
            end
            if (load_freq) begin
                freq_sh   <= shift_q[FREQ_W-1:0];
                pend_freq <= 1'b1;
            end
            if (load_phase) begin
                phase_sh   <= shift_q[PHASE_W-1:0];
                pend_phase <= 1'b1;
            end
            if (load_amp) begin
                amp_sh   <= shift_q[AMP_W-1:0];
                pend_amp <= 1'b1;
            end
        end
    end

`ifdef DDS_RX_ERR_CNT_EN
    // Saturating frame error counter, cleared only by reset_in.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            err_cnt_out <= '0;
        end else if (frame_err_out && (err_cnt_out != {ERR_CNT_W{1'b1}})) begin
            err_cnt_out <= err_cnt_out + ERR_CNT_W'(1);
        end
    end
`endif

    // Length code and the oldest shift bit carry no information here.
    logic unused_bits;
    assign unused_bits = ^{shift_q[SHIFT_W-1], instr_q.len};

endmodule
